// File: rtl/mole_game_pkg.sv
// Shared constants for the whack-a-mole controller: state encoding, LFSR
// shape and the width helper used for the round timer.
package mole_game_pkg;

  typedef enum logic [1:0] {
    ST_LOBBY = 2'd0,
    ST_PLAY  = 2'd1,
    ST_OVER  = 2'd2
  } game_state_t;

  localparam int LFSR_W = 16;
  // Right-shifting Fibonacci form of taps 16,14,13,11: bits 0,2,3,5 feed bit 15.
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 16'h002D;

  function automatic int time_w(input int max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR used to pick the next mole hole.
module mole_lfsr16
  import mole_game_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [LFSR_W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= SEED;
    end else begin
      value <= {^(value & LFSR_TAP_MASK), value[LFSR_W-1:1]};
    end
  end

endmodule

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: lobby/play/over sequencing, tick divider,
// pseudo-random mole spawning, mole and round timing, hit/miss scoring.
module mole_game_ctrl
  import mole_game_pkg::*;
#(
  parameter int                NUM_HOLES   = 9,
  parameter int                TICK_DIV    = 5000000,
  parameter int                ROUND_TICKS = 300,
  parameter int                MOLE_TICKS  = 10,
  parameter int                GAP_TICKS   = 2,
  parameter int                SCORE_W     = 8,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                           CLOCK_50,
  input  logic                           reset,
  input  logic                           iStart,
  input  logic [NUM_HOLES-1:0]           hit,
  output logic [1:0]                     state,
  output logic [1:0]                     screen_sel,
  output logic [NUM_HOLES-1:0]           board_out,
  output logic [SCORE_W-1:0]             score,
  output logic [SCORE_W-1:0]             misses,
  output logic [time_w(ROUND_TICKS)-1:0] time_left,
  output logic                           hit_pulse,
  output logic                           miss_pulse
);

  localparam int TW = time_w(ROUND_TICKS);
  localparam int CW = $clog2(TICK_DIV);
  localparam int IW = $clog2(NUM_HOLES);
  localparam int AW = time_w(MOLE_TICKS);
  localparam int GW = time_w(GAP_TICKS);

  game_state_t          state_q, state_d;
  logic                 start_q;
  logic [NUM_HOLES-1:0] hit_q;
  logic [CW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [NUM_HOLES-1:0] board_q, board_d;
  logic [SCORE_W-1:0]   score_q, score_d, miss_q, miss_d;
  logic [TW-1:0]        time_q, time_d;
  logic                 hp_q, hp_d, mp_q, mp_d;
  logic                 spawn_q, spawn_d;
  logic [IW-1:0]        prev_q, prev_d;
  logic                 prev_vld_q, prev_vld_d;
  logic [AW-1:0]        age_q, age_d;
  logic [GW-1:0]        gap_q, gap_d;

  logic [LFSR_W-1:0]    lfsr_value;
  logic [IW-1:0]        raw_idx, spawn_idx;
  logic [NUM_HOLES-1:0] spawn_onehot, hit_edge;
  logic                 start_edge, tick, correct_hit, any_hit;

  mole_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (CLOCK_50),
    .rst_n (reset),
    .value (lfsr_value)
  );

  // Never repeat the previous hole: step to the next one, wrapping at NUM_HOLES.
  assign raw_idx      = IW'(lfsr_value % LFSR_W'(NUM_HOLES));
  assign spawn_idx    = (prev_vld_q && (raw_idx == prev_q))
                      ? ((raw_idx == IW'(NUM_HOLES-1)) ? '0 : raw_idx + 1'b1)
                      : raw_idx;
  assign spawn_onehot = NUM_HOLES'(1) << spawn_idx;

  assign start_edge  = iStart & ~start_q;
  assign hit_edge    = hit & ~hit_q;
  assign tick        = (state_q == ST_PLAY) && (tick_cnt_q == CW'(TICK_DIV-1));
  assign correct_hit = |(hit_edge & board_q);
  assign any_hit     = |hit_edge;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_LOBBY;
      start_q    <= 1'b0;
      hit_q      <= '0;
      tick_cnt_q <= '0;
      board_q    <= '0;
      score_q    <= '0;
      miss_q     <= '0;
      time_q     <= TW'(ROUND_TICKS);
      hp_q       <= 1'b0;
      mp_q       <= 1'b0;
      spawn_q    <= 1'b0;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      age_q      <= '0;
      gap_q      <= '0;
    end else begin
      state_q    <= state_d;
      start_q    <= iStart;
      hit_q      <= hit;
      tick_cnt_q <= tick_cnt_d;
      board_q    <= board_d;
      score_q    <= score_d;
      miss_q     <= miss_d;
      time_q     <= time_d;
      hp_q       <= hp_d;
      mp_q       <= mp_d;
      spawn_q    <= spawn_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      age_q      <= age_d;
      gap_q      <= gap_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    board_d    = board_q;
    score_d    = score_q;
    miss_d     = miss_q;
    time_d     = time_q;
    hp_d       = 1'b0;
    mp_d       = 1'b0;
    spawn_d    = spawn_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    age_d      = age_q;
    gap_d      = gap_q;

    case (state_q)
      ST_LOBBY: begin
        board_d = '0;
        if (start_edge) begin
          state_d    = ST_PLAY;
          score_d    = '0;
          miss_d     = '0;
          time_d     = TW'(ROUND_TICKS);
          spawn_d    = 1'b1;
          tick_cnt_d = '0;
          prev_vld_d = 1'b0;
          age_d      = '0;
          gap_d      = '0;
        end
      end

      ST_PLAY: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

        if (spawn_q) begin
          board_d    = spawn_onehot;
          prev_d     = spawn_idx;
          prev_vld_d = 1'b1;
          age_d      = '0;
          spawn_d    = 1'b0;
        end

        // A correct hit beats both a wrong bit and a mole expiry in the same cycle.
        if (correct_hit) begin
          score_d = (&score_q) ? score_q : score_q + 1'b1;
          hp_d    = 1'b1;
          board_d = '0;
          gap_d   = GW'(GAP_TICKS);
        end else begin
          if (any_hit) begin
            miss_d = (&miss_q) ? miss_q : miss_q + 1'b1;
            mp_d   = 1'b1;
          end
          if (tick && (|board_q)) begin
            if (age_q == AW'(MOLE_TICKS-1)) begin
              board_d = '0;
              gap_d   = GW'(GAP_TICKS);
            end else begin
              age_d = age_q + 1'b1;
            end
          end else if (tick && (gap_q != '0)) begin
            gap_d = gap_q - 1'b1;
            if (gap_q == GW'(1)) begin
              spawn_d = 1'b1;
            end
          end
        end

        if (tick) begin
          time_d = time_q - 1'b1;
          if (time_q == TW'(1)) begin
            state_d = ST_OVER;
            board_d = '0;
            spawn_d = 1'b0;
            gap_d   = '0;
          end
        end
      end

      ST_OVER: begin
        board_d = '0;
        if (start_edge) begin
          state_d = ST_LOBBY;
        end
      end

      default: begin
        state_d = ST_LOBBY;
        board_d = '0;
      end
    endcase
  end

  assign state      = state_q;
  assign screen_sel = state_q;
  assign board_out  = board_q;
  assign score      = score_q;
  assign misses     = miss_q;
  assign time_left  = time_q;
  assign hit_pulse  = hp_q;
  assign miss_pulse = mp_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl: table vectors, a random run against a
// game-rule reference model, and directed corner sequences.
module tb_mole_game_ctrl;
  import mole_game_pkg::*;

  localparam int N  = 9;
  localparam int TD = 4;
  localparam int RT = 12;
  localparam int MT = 3;
  localparam int GT = 1;
  localparam int TW = time_w(RT);

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          iStart = 1'b0;
  logic [N-1:0]  hit = '0;

  logic [1:0]    state, screen_sel, state2, screen_sel2;
  logic [N-1:0]  board_out, board2;
  logic [7:0]    score, misses;
  logic [1:0]    score2, misses2;
  logic [TW-1:0] time_left, time_left2;
  logic          hit_pulse, miss_pulse, hp2, mp2;

  always #5 clock = ~clock;

  mole_game_ctrl #(
    .NUM_HOLES(N), .TICK_DIV(TD), .ROUND_TICKS(RT), .MOLE_TICKS(MT),
    .GAP_TICKS(GT), .SCORE_W(8), .LFSR_SEED(16'hACE1)
  ) dut (
    .CLOCK_50(clock), .reset(reset), .iStart(iStart), .hit(hit),
    .state(state), .screen_sel(screen_sel), .board_out(board_out),
    .score(score), .misses(misses), .time_left(time_left),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  // Narrow-counter twin sharing every input, so its board tracks the main DUT.
  mole_game_ctrl #(
    .NUM_HOLES(N), .TICK_DIV(TD), .ROUND_TICKS(RT), .MOLE_TICKS(MT),
    .GAP_TICKS(GT), .SCORE_W(2), .LFSR_SEED(16'hACE1)
  ) dut2 (
    .CLOCK_50(clock), .reset(reset), .iStart(iStart), .hit(hit),
    .state(state2), .screen_sel(screen_sel2), .board_out(board2),
    .score(score2), .misses(misses2), .time_left(time_left2),
    .hit_pulse(hp2), .miss_pulse(mp2)
  );

  int vec_count = 0;
  int miscompares = 0;

  // Reference model: hole as an integer, ticks from cycles since round start.
  int          m_state, m_cyc, m_hole, m_prev, m_age, m_gap;
  int          m_score, m_misses, m_time;
  bit          m_spawn, m_hp, m_mp, m_start_q;
  logic [N-1:0] m_hit_q;
  logic [15:0] m_lfsr;

  typedef struct {
    logic         start;
    logic [N-1:0] hitv;
    logic [1:0]   st;
    logic         up;
    int           sc;
    int           ms;
    int           tl;
    logic         hp;
    logic         mp;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_cyc = 0; m_hole = -1; m_prev = -1; m_age = 0; m_gap = 0;
    m_score = 0; m_misses = 0; m_time = RT;
    m_spawn = 0; m_hp = 0; m_mp = 0; m_start_q = 0; m_hit_q = '0;
    m_lfsr = 16'hACE1;
  endtask

  task automatic model_step(input logic s, input logic [N-1:0] h);
    int           cur_hole;
    int           idx;
    bit           se, tick;
    logic [N-1:0] he;
    cur_hole = m_hole;
    se = s && !m_start_q;
    he = h & ~m_hit_q;
    m_hp = 0;
    m_mp = 0;
    case (m_state)
      0: if (se) begin
        m_state = 1; m_score = 0; m_misses = 0; m_time = RT;
        m_spawn = 1; m_cyc = 0; m_prev = -1; m_gap = 0; m_hole = -1;
      end
      1: begin
        tick = (m_cyc % TD) == TD - 1;
        m_cyc++;
        if (m_spawn) begin
          idx = m_lfsr % N;
          if (idx == m_prev) idx = (idx + 1) % N;
          m_hole = idx; m_prev = idx; m_age = 0; m_spawn = 0;
        end
        if (cur_hole >= 0 && he[cur_hole]) begin
          m_score++; m_hp = 1; m_hole = -1; m_gap = GT;
        end else begin
          if (he != '0) begin m_misses++; m_mp = 1; end
          if (tick && cur_hole >= 0) begin
            if (m_age == MT - 1) begin m_hole = -1; m_gap = GT; end
            else m_age++;
          end else if (tick && m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) m_spawn = 1;
          end
        end
        if (tick) begin
          m_time--;
          if (m_time == 0) begin m_state = 2; m_hole = -1; m_spawn = 0; m_gap = 0; end
        end
      end
      default: if (se) m_state = 0;
    endcase
    m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    m_start_q = s;
    m_hit_q = h;
  endtask

  task automatic apply_stimulus(input logic s, input logic [N-1:0] h);
    iStart = s;
    hit = h;
    @(posedge clock);
    model_step(s, h);
    #1;
  endtask

  task automatic check_output();
    check("state", state, m_state);
    check("screen_sel", screen_sel, m_state);
    check("board_out", board_out, onehot(m_hole));
    check("score", score, sat(m_score, 255));
    check("misses", misses, sat(m_misses, 255));
    check("time_left", time_left, m_time);
    check("hit_pulse", hit_pulse, m_hp);
    check("miss_pulse", miss_pulse, m_mp);
    check("w2_state", state2, m_state);
    check("w2_screen_sel", screen_sel2, m_state);
    check("w2_board", board2, onehot(m_hole));
    check("w2_score", score2, sat(m_score, 3));
    check("w2_misses", misses2, sat(m_misses, 3));
    check("w2_time_left", time_left2, m_time);
    check("w2_pulses", {hp2, mp2}, {m_hp, m_mp});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, state, 0);
    check({tag, "_board"}, board_out, 0);
    check({tag, "_score"}, score, 0);
    check({tag, "_misses"}, misses, 0);
    check({tag, "_time_left"}, time_left, RT);
    check({tag, "_pulses"}, {hit_pulse, miss_pulse}, 0);
    check({tag, "_w2_score"}, score2, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    iStart = 1'b0;
    hit = '0;
    model_reset();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    logic         s_r;
    logic [N-1:0] h_r, last_h, h;
    bit           early_done, is_final;

    tbl[0]  = '{1'b0, 9'h000, 2'd0, 1'b0, 0, 0, 12, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 9'h000, 2'd1, 1'b0, 0, 0, 12, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 9'h000, 2'd1, 1'b1, 0, 0, 12, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 9'h000, 2'd1, 1'b1, 0, 0, 12, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 9'h000, 2'd1, 1'b1, 0, 0, 12, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 9'h000, 2'd1, 1'b1, 0, 0, 11, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 9'h1FF, 2'd1, 1'b0, 1, 0, 11, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 9'h1FF, 2'd1, 1'b0, 1, 0, 11, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 9'h000, 2'd1, 1'b0, 1, 0, 11, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 9'h1FF, 2'd1, 1'b0, 1, 1, 10, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 9'h1FF, 2'd1, 1'b1, 1, 1, 10, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 9'h000, 2'd1, 1'b1, 1, 1, 10, 1'b0, 1'b0};

    reset = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    check_reset_values("reset");
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply_stimulus(tbl[i].start, tbl[i].hitv);
      check($sformatf("v%0d_state", i), state, tbl[i].st);
      if (tbl[i].up) check($sformatf("v%0d_onehot", i), $onehot(board_out), 1);
      else           check($sformatf("v%0d_board", i), board_out, 0);
      check($sformatf("v%0d_score", i), score, tbl[i].sc);
      check($sformatf("v%0d_misses", i), misses, tbl[i].ms);
      check($sformatf("v%0d_time_left", i), time_left, tbl[i].tl);
      check($sformatf("v%0d_pulses", i), {hit_pulse, miss_pulse}, {tbl[i].hp, tbl[i].mp});
    end

    s_r = 1'b0;
    h_r = '0;
    for (int i = 0; i < 1500; i++) begin
      int r;
      if ($urandom_range(0, 99) < 4) s_r = ~s_r;
      r = $urandom_range(0, 99);
      if (r < 50)      h_r = h_r;
      else if (r < 70) h_r = '0;
      else if (r < 82) h_r = onehot(m_hole);
      else if (r < 90) h_r = onehot($urandom_range(0, N-1));
      else if (r < 95) h_r = onehot(m_hole) | onehot($urandom_range(0, N-1));
      else             h_r = N'($urandom);
      apply_stimulus(s_r, h_r);
      check_output();
    end

    // Five correct hits, then an asynchronous reset in the middle of play.
    do_reset();
    apply_stimulus(1'b1, '0);
    check_output();
    last_h = '0;
    for (int i = 0; i < 60 && m_score < 5 && m_state == 1; i++) begin
      h = (m_hole >= 0 && last_h == '0) ? onehot(m_hole) : '0;
      apply_stimulus(1'b0, h);
      check_output();
      last_h = h;
    end
    check("five_hit_score", score, 5);
    check("w2_saturated_score", score2, 3);
    check("five_hit_state", state, 1);
    #1;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    model_reset();
    @(negedge clock);
    reset = 1'b1;

    // Round with a hit landing on the final tick; iStart stays high throughout.
    apply_stimulus(1'b1, '0);
    check_output();
    early_done = 0;
    is_final = 0;
    for (int i = 0; i < 70 && m_state == 1; i++) begin
      h = '0;
      if (!early_done && m_hole >= 0 && m_time <= 3) begin
        h = onehot(m_hole);
        early_done = 1;
      end
      is_final = (m_time == 1) && ((m_cyc % TD) == TD - 1);
      if (is_final) h = onehot(m_hole);
      apply_stimulus(1'b1, h);
      check_output();
    end
    check("final_tick_state", state, 2);
    check("final_tick_score", score, 2);
    check("final_tick_board", board_out, 0);
    check("final_tick_time_left", time_left, 0);
    check("final_tick_hit_pulse", hit_pulse, 1);

    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, (i % 2 == 0) ? N'($urandom) | 9'h001 : '0);
      check_output();
      check($sformatf("over_hold%0d_score", i), score, 2);
      check($sformatf("over_hold%0d_misses", i), misses, 0);
      check($sformatf("over_hold%0d_state", i), state, 2);
    end
    apply_stimulus(1'b0, '0);
    check_output();
    apply_stimulus(1'b1, '0);
    check_output();
    check("over_to_lobby_state", state, 0);
    check("lobby_keeps_score", score, 2);
    apply_stimulus(1'b0, '0);
    check_output();
    apply_stimulus(1'b1, '0);
    check_output();
    check("replay_state", state, 1);
    check("replay_score_cleared", score, 0);
    check("replay_time_left", time_left, RT);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
